// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with post-reset zeroing sweep and RAW busy scoreboard.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through to the read ports.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  set_busy,
  input  logic [AW-1:0]         set_addr,
  output logic                  ready
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_next;
  logic [AW-1:0]     idx, idx_next;
  logic [NREGS-1:0]  busy, busy_next;
  logic [XLEN-1:0]   rf [NREGS];
  logic              wr_en;

  assign wr_en = (state == RUN) && we && (waddr != '0);
  assign ready = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      idx   <= AW'(1);
      busy  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      busy  <= busy_next;
    end
  end

  // Set is applied after clear so a newly issued producer wins over a retiring one.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    busy_next  = busy;
    if (state == INIT) begin
      idx_next  = idx + AW'(1);
      busy_next = '0;
      if (idx == AW'(NREGS - 1)) state_next = RUN;
    end else begin
      if (wr_en) busy_next[waddr] = 1'b0;
      if (set_busy && (set_addr != '0)) busy_next[set_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state == INIT) rf[idx] <= '0;
    else if (wr_en)    rf[waddr] <= wdata;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign a = raddr[k*AW +: AW];

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if ((state == RUN) && (a != '0)) begin
        rd = rf[a];
        rb = busy[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (waddr == a)) begin
          rd = wdata;
          rb = set_busy && (set_addr == waddr);
        end
`endif
      end
    end

    assign rdata[k*XLEN +: XLEN] = rd;
    assign rbusy[k]              = rb;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file for the pipelined core, replacing the fixed 32x32, 2-read register file. After reset a sequencer zeroes every architectural register so software never sees X state. It also keeps a per-register busy scoreboard that the decode stage uses for RAW hazard detection. It sits between decode (reads, busy marking) and writeback (writes, busy clearing).

## Interface
- XLEN, default 32: register width in bits.
- NREGS, default 32: number of registers; power of two, at least 4; register 0 is hardwired zero.
- NREAD, default 2: number of independent read ports, 1 to 4.
- AW, derived as $clog2(NREGS): address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- raddr  in  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
- rdata  out  NREAD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]; combinational.
- rbusy  out  NREAD  port k's register has a pending write.
- we  in  1  writeback write enable.
- waddr  in  AW  writeback address.
- wdata  in  XLEN  writeback data.
- set_busy  in  1  decode issued an instruction writing set_addr.
- set_addr  in  AW  destination being marked busy.
- ready  out  1  initialisation done; register file usable.

## Operation
- States: INIT and RUN. Asynchronous reset forces INIT, idx=1, all busy bits 0, ready=0.
- INIT, on each edge:
  - RF[idx] <= 0, idx <= idx+1.
  - The edge that clears RF[NREGS-1] moves to RUN and sets ready=1.
  - we and set_busy are ignored.
  - All rdata are forced to 0 and all rbusy to 0.
- RUN, writes: we && waddr!=0 writes RF[waddr] <= wdata at the edge. Writes to register 0 are discarded.
- RUN, reads: rdata[k] = 0 if raddr[k]==0, else RF[raddr[k]].
- Scoreboard: busy[0] is constant 0. For r!=0, next busy[r]:
  - set to 1 if set_busy && set_addr==r;
  - else cleared to 0 if we && waddr==r;
  - else held.
- Set and clear of the same register in the same cycle: set wins, because a new producer was issued while the old one retires.
- Clearing a register that is not busy is legal and has no effect.
- rbusy[k] = busy[raddr[k]] (without bypass; see Configuration).
- Multiple read ports may address the same register; each returns identical data and busy.
- Asynchronous reset mid-RUN re-enters INIT. Storage is not asynchronously cleared; the INIT sweep re-zeroes it.

## Timing
- Reset values: ready=0, rbusy=0, rdata=0.
- INIT lasts NREGS-1 rising edges after rst_n deasserts. Default: ready rises on the 31st edge.
- Write latency is 1 edge: a read in the cycle after the write sees the new data.
- Read latency is 0: combinational from raddr and storage.
- Busy set and clear take effect at the edge; rbusy reflects them from the following cycle.
- No backpressure; all inputs are sampled every RUN cycle.

## Configuration
- REGFILE_BYPASS_EN defined: write-through bypass.
  - When we && waddr!=0 && raddr[k]==waddr, rdata[k]=wdata in the same cycle.
  - In that case rbusy[k]=0 unless set_busy && set_addr==waddr in that cycle.
  - Lets decode read a value in its writeback cycle without stalling.
- REGFILE_BYPASS_EN undefined:
  - rdata[k] returns the pre-write value in the write cycle.
  - rbusy[k] reflects the registered busy bit only.
- Register 0 behaviour is identical in both builds.

## Test plan
- Release reset, count edges -> ready=0 for 30 edges and 1 after the 31st; reading regs 1..31 then returns 0 on every port.
- RUN: we=1, waddr=5, wdata=0xDEADBEEF for 1 cycle, then raddr0=5, raddr1=5 -> both ports 0xDEADBEEF. Then write 0x1234 to reg 0 -> a read of reg 0 returns 0.
- set_busy with set_addr=7 -> rbusy=1 next cycle for raddr=7. Then we to reg 7 -> rbusy=0 next cycle. Then set_busy and we both on reg 7 in one cycle -> rbusy stays 1.
- Same-cycle write and read of reg 9 with wdata=0xA5A5A5A5 (old value 0x11) -> 0xA5A5A5A5 and rbusy=0 with REGFILE_BYPASS_EN; 0x11 without it, and 0xA5A5A5A5 the following cycle.
- Write reg 3 to 0xFF and mark reg 4 busy, then pulse rst_n low mid-RUN -> ready=0 and rbusy=0 immediately; after 31 edges reg 3 reads 0 and reg 4 is not busy.
- Edge cases: set_busy and we during INIT -> no busy bits set and no data written once ready rises. Run with NREGS=8, NREAD=3 -> ready after 7 edges; all three ports read independently.
